// File: rtl/dds_sig_src.sv
// Burst-capable DDS test-tone source: signed 16-bit quarter-wave sine
// with a one-cycle valid strobe, programmable rate, length and attenuation.
module dds_sig_src #(
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 16,
  parameter int LEN_W   = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic               i_Stop,
  input  logic [PHASE_W-1:0] i_Fcw,
  input  logic [DIV_W-1:0]   i_Div,
  input  logic [LEN_W-1:0]   i_Len,
  input  logic [3:0]         i_Amp_Shift,
  output logic               o_Vld,
  output logic [15:0]        o_Dout,
  output logic               o_Busy,
  output logic               o_Done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PHASE_W-1:0] fcw;
  logic [DIV_W-1:0]   div;
  logic [LEN_W-1:0]   len;
  logic [3:0]         amp;

  logic [PHASE_W-1:0] phase;
  logic [DIV_W-1:0]   div_cnt;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_inc;
  logic [1:0]         fl_cnt;
  logic               tick;

  logic               s1_vld;
  logic [1:0]         s1_q;
  logic [7:0]         s1_a;
  logic [7:0]         s1_addr;
  logic               s2_vld;
  logic               s2_neg;
  logic [14:0]        s2_mag;
  logic signed [15:0] samp;
  logic signed [15:0] samp_sh;

  // Quarter-wave table evaluated at elaboration by a Taylor series,
  // so no external memory image is needed.
  function automatic int lut_val(input int k);
    real x;
    real x2;
    real term;
    real s;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0;
    x2   = x * x;
    term = x;
    s    = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return int'(32767.0 * s);
  endfunction

  logic [14:0] lut [256];

  for (genvar k = 0; k < 256; k++) begin : g_lut
    localparam int V = lut_val(k);
    assign lut[k] = 15'(V);
  end

  assign cnt_inc = cnt + 1'b1;
  assign o_Busy  = (state != IDLE);

  always_comb begin
    state_nx = state;
    tick     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_Start) state_nx = RUN;
      end
      RUN: begin
        if (i_Stop) begin
          state_nx = FLUSH;
        end else if (div_cnt == '0) begin
          tick = 1'b1;
          if (len != '0 && cnt_inc == len)
            state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (fl_cnt == 2'd2) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state   <= IDLE;
      fcw     <= '0;
      div     <= '0;
      len     <= '0;
      amp     <= '0;
      phase   <= '0;
      div_cnt <= '0;
      cnt     <= '0;
      fl_cnt  <= '0;
      o_Done  <= 1'b0;
    end else begin
      state  <= state_nx;
      o_Done <= (state == FLUSH) && (state_nx == IDLE);
      fl_cnt <= (state == FLUSH) ? fl_cnt + 2'd1 : 2'd0;
      if (state == IDLE && i_Start) begin
        fcw     <= i_Fcw;
        div     <= i_Div;
        len     <= i_Len;
        amp     <= i_Amp_Shift;
        phase   <= '0;
        div_cnt <= '0;
        cnt     <= '0;
      end else if (tick) begin
        phase   <= phase + fcw;
        div_cnt <= div;
        cnt     <= cnt_inc;
      end else if (state == RUN && !i_Stop) begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

  // Mirror the address in odd quadrants; 255-a is just ~a.
  assign s1_addr = s1_q[0] ? ~s1_a : s1_a;
  assign samp    = s2_neg ? -$signed({1'b0, s2_mag})
                          : $signed({1'b0, s2_mag});
  assign samp_sh = samp >>> amp;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
      s1_a   <= '0;
      s2_vld <= 1'b0;
      s2_neg <= 1'b0;
      s2_mag <= '0;
      o_Vld  <= 1'b0;
      o_Dout <= '0;
    end else begin
      s1_vld <= tick;
      if (tick) begin
        s1_q <= phase[PHASE_W-1 -: 2];
        s1_a <= phase[PHASE_W-3 -: 8];
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mag <= lut[s1_addr];
        s2_neg <= s1_q[1];
      end
      o_Vld <= s2_vld;
      if (s2_vld) o_Dout <= samp_sh;
    end
  end

endmodule
